// File: rtl/fft16_pkg.sv
// Shared constants, FSM state type and bus slicing helper for the FFT16 input buffer.
package fft16_pkg;

  localparam int N_POINTS = 16;
  localparam int IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Low bit of sample k on a flattened bus of w-bit words.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fft16_frame_bank.sv
// One 16-entry complex sample bank; single write port, all entries visible on flat buses.
module fft16_frame_bank
  import fft16_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic [IDX_W-1:0]                widx,
  input  logic [WORD_SIZE-1:0]            wre,
  input  logic [WORD_SIZE-1:0]            wim,
  output logic [N_POINTS*WORD_SIZE-1:0]   re,
  output logic [N_POINTS*WORD_SIZE-1:0]   im
);

  logic [WORD_SIZE-1:0] mem_re [N_POINTS];
  logic [WORD_SIZE-1:0] mem_im [N_POINTS];

  // Sample storage: cleared on reset, one entry written per accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_POINTS; k++) begin
        mem_re[k] <= '0;
        mem_im[k] <= '0;
      end
    end else if (we) begin
      mem_re[widx] <= wre;
      mem_im[widx] <= wim;
    end
  end

  for (genvar k = 0; k < N_POINTS; k++) begin : g_flat
    assign re[slice_lo(k, WORD_SIZE) +: WORD_SIZE] = mem_re[k];
    assign im[slice_lo(k, WORD_SIZE) +: WORD_SIZE] = mem_im[k];
  end

endmodule

// File: rtl/fft16_input_buffer.sv
// Ping-pong frame assembler feeding FFT16_top: serial valid/ready samples in,
// one 16-sample frame presented in parallel with a start strobe, held until
// the FFT signals completion.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no frame presented; waiting for bank rd_bank to fill
// START | frame in rd_bank valid; o_start pulses for this one cycle
// WAIT  | FFT working on rd_bank; release on i_fft_done
module fft16_input_buffer #(
  parameter int WORD_SIZE = 16,
  parameter int N_POINTS  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic [WORD_SIZE-1:0]          i_re,
  input  logic [WORD_SIZE-1:0]          i_im,
  output logic                          o_ready,
  output logic [N_POINTS*WORD_SIZE-1:0] o_frame_re,
  output logic [N_POINTS*WORD_SIZE-1:0] o_frame_im,
  output logic                          o_start,
  input  logic                          i_fft_done,
  output logic                          o_busy,
  output logic [7:0]                    o_frame_cnt
);

  import fft16_pkg::*;

  if (N_POINTS != fft16_pkg::N_POINTS) begin : g_bad_n_points
    $error("fft16_input_buffer supports only N_POINTS = 16");
  end

  state_t                        state, state_nxt;
  logic                          wr_bank, rd_bank;
  logic [IDX_W-1:0]              wr_idx;
  logic [1:0]                    bank_full, bank_full_nxt;
  logic                          xfer, last_xfer, rel_frame;
  logic [N_POINTS*WORD_SIZE-1:0] b0_re, b0_im, b1_re, b1_im;

  assign o_ready   = ~bank_full[wr_bank];
  assign xfer      = i_valid & o_ready;
  assign last_xfer = xfer & (wr_idx == LAST_IDX);
  assign rel_frame = (state == WAIT) & i_fft_done;
  assign o_busy    = (state != IDLE);

  fft16_frame_bank #(.WORD_SIZE(WORD_SIZE)) u_bank0 (
    .clk  (i_clk),
    .rst  (i_rst),
    .we   (xfer & ~wr_bank),
    .widx (wr_idx),
    .wre  (i_re),
    .wim  (i_im),
    .re   (b0_re),
    .im   (b0_im)
  );

  fft16_frame_bank #(.WORD_SIZE(WORD_SIZE)) u_bank1 (
    .clk  (i_clk),
    .rst  (i_rst),
    .we   (xfer & wr_bank),
    .widx (wr_idx),
    .wre  (i_re),
    .wim  (i_im),
    .re   (b1_re),
    .im   (b1_im)
  );

  // The read bank is always full while presented, so this mux is stable from START to release.
  assign o_frame_re = rd_bank ? b1_re : b0_re;
  assign o_frame_im = rd_bank ? b1_im : b0_im;

  // Full flags: release and fill always target different banks, so both may happen in one cycle.
  always_comb begin
    bank_full_nxt = bank_full;
    if (rel_frame) bank_full_nxt[rd_bank] = 1'b0;
    if (last_xfer) bank_full_nxt[wr_bank] = 1'b1;
  end

  // Read FSM next state and Moore start strobe.
  always_comb begin
    state_nxt = state;
    o_start   = 1'b0;
    case (state)
      IDLE:    if (bank_full[rd_bank]) state_nxt = START;
      START: begin
        o_start   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (i_fft_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write pointer, bank pointers, full flags, FSM state and frame counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_idx      <= '0;
      bank_full   <= 2'b00;
      o_frame_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      bank_full <= bank_full_nxt;
      if (xfer) begin
        wr_idx <= last_xfer ? '0 : wr_idx + IDX_W'(1);
        if (last_xfer) wr_bank <= ~wr_bank;
      end
      if (rel_frame) begin
        rd_bank     <= ~rd_bank;
        o_frame_cnt <= o_frame_cnt + 8'd1;
      end
    end
  end

endmodule
